data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, meaning number of 8-bit data-memory words (legal range 2..256).
REQ-002 Parameter WAIT_STATES, default 2, meaning extra access cycles per legal access (legal range 0..7).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 memread  input  1  read request from control unit.
REQ-006 memwrite  input  1  write request from control unit.
REQ-007 addr  input  8  word address from ALU result.
REQ-008 wdata  input  8  store data.
REQ-009 rdata  output  8  registered load data.
REQ-010 rvalid  output  1  one-cycle pulse: read completed, rdata updated.
REQ-011 wack  output  1  one-cycle pulse: write committed.
REQ-012 err  output  1  one-cycle pulse: request rejected.
REQ-013 stall  output  1  pipeline hold; requester SHALL keep memread/memwrite/addr/wdata stable while stall=1.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, DONE; reset state IDLE.
REQ-015 Request SHALL be sampled only in IDLE; request = memread|memwrite.
REQ-016 stall SHALL be combinational: 1 when (IDLE and request) or WAIT; 0 in DONE and in IDLE without request.
REQ-017 IDLE, legal request, WAIT_STATES>0: next state WAIT, wait counter loaded with WAIT_STATES-1.
REQ-018 IDLE, legal request, WAIT_STATES=0: next state DONE directly.
REQ-019 WAIT: counter decrements each cycle; counter=0 -> next state DONE.
REQ-020 Legal access: memory write or read capture SHALL occur on the clock edge entering DONE; latency request-cycle to rvalid/wack = WAIT_STATES+1 cycles.
REQ-021 DONE: rvalid=1 (read) or wack=1 (write) for exactly that cycle; stall=0; next state IDLE unconditionally; request still present in DONE SHALL NOT be re-accepted.
REQ-022 Back-to-back requests: new request earliest accepted in the IDLE cycle after DONE (one bubble).
REQ-023 Illegal request (memread&memwrite both 1, or addr>=DEPTH): no memory access, no WAIT; next state DONE with err=1, rvalid=0, wack=0, rdata unchanged.
REQ-024 rdata SHALL hold last successful read value until next successful read.
REQ-025 rvalid, wack, err SHALL be mutually exclusive and registered (asserted only in DONE).

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, rdata 0x00, rvalid/wack/err 0; stall then follows REQ-016.
REQ-027 Reset before the commit edge of a write SHALL leave that word unmodified; memory array contents SHALL NOT be cleared by reset.
REQ-028 After rst_n deasserts, a request held high SHALL be accepted as a new request in IDLE.

Structure
REQ-029 Shared package SHALL hold: FSM state enum, DATA_W=8, ADDR_W=8, default DEPTH and WAIT_STATES.
REQ-030 Storage SHALL be one sub-module dmem_array (DEPTH x 8, synchronous write, synchronous read, single port) instantiated by data_mem_ctrl.
REQ-031 data_mem_ctrl SHALL contain the FSM, wait counter, legality check and output registers only.

Verification
REQ-032 Write addr=0x05 wdata=0xA5 (WAIT_STATES=2) -> stall=1 cycles 0..2, wack=1 cycle 3, stall=0 cycle 3.
REQ-033 Then read addr=0x05 -> rvalid=1 with rdata=0xA5 exactly 3 cycles after request cycle; rdata stays 0xA5 afterwards.
REQ-034 memread=memwrite=1 addr=0x01, and separately read addr=0x40 (DEPTH=32) -> err=1 next cycle, stall 1 cycle only, rdata unchanged, memory unchanged.
REQ-035 Write addr=0x07 wdata=0x3C, rst_n=0 during WAIT cycle 1 -> outputs zero immediately, later read of 0x07 returns prior value, not 0x3C.
REQ-036 WAIT_STATES=0 build: read held continuously for 6 cycles -> rvalid pattern 0,1,0,1,0,1 (request, DONE, IDLE-accept...), stall pattern 1,0,1,0,1,0.
REQ-037 Back-to-back write 0x10<-0x11 then read 0x10 with requests held -> one idle-accept bubble, read returns 0x11.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_pkg
// Purpose : Shared definitions for the data-memory controller slice: bus
//           widths, default build parameters, wait-counter width and the
//           controller FSM state encoding.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package data_mem_ctrl_pkg;

  localparam int DATA_W          = 8;   // data word width
  localparam int ADDR_W          = 8;   // word address width
  localparam int DEF_DEPTH       = 32;  // default number of memory words
  localparam int DEF_WAIT_STATES = 2;   // default extra access cycles
  localparam int CNT_W           = 3;   // wait counter holds 0..7

  // Encoding is visible on the state_dbg port of the controller.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Purpose : Single-port DEPTH x 8 data memory. Synchronous write and
//           synchronous (registered) read. The read register holds its value
//           until the next read and is the load-data register seen by the
//           pipeline. Memory contents are never cleared by reset.
// Ports   : clk    - clock, rising edge
//           rst_n  - async active-low reset, clears the read register only
//           en     - access strobe for this clock edge
//           we     - 1 = write, 0 = read (qualified by en)
//           addr   - word index (already range-checked by the controller)
//           wdata  - write data
//           rdata  - registered read data
// -----------------------------------------------------------------------------
module dmem_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage has no reset so that a reset never disturbs memory contents.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Purpose : Data-memory controller for a simple pipelined CPU. Accepts one
//           read or write request at a time, inserts WAIT_STATES extra
//           cycles, then reports completion (rvalid / wack) or rejection
//           (err) with a one-cycle pulse in the DONE state.
// Ports   : clk, rst_n       - clock (rising edge), async active-low reset
//           memread/memwrite - request from the control unit
//           addr, wdata      - word address and store data
//           rdata            - registered load data (holds until next read)
//           rvalid/wack/err  - one-cycle completion pulses (mutually excl.)
//           stall            - combinational pipeline hold
//           state_dbg        - current FSM state (ST_* encoding)
//
// Handshake: a request (memread|memwrite) is sampled only in IDLE. From that
// cycle the controller drives stall=1 until the DONE cycle; while stall=1 the
// requester must keep memread/memwrite/addr/wdata stable. In DONE stall=0,
// the pulse for the access is high for that one cycle, and any request still
// present is ignored; it is taken up in the following IDLE cycle.
// -----------------------------------------------------------------------------
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              err,
  output logic              stall,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH=256 is representable in the range compare.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              request;
  logic              illegal;
  logic              access;
  logic              rvalid_nxt, wack_nxt, err_nxt;

  assign request   = memread | memwrite;
  assign illegal   = (memread & memwrite) | ({1'b0, addr} >= DEPTH_LIM);
  assign state_dbg = state;

  // Next state, wait counter and pulse flags. The memory strobe (access) is
  // raised in the cycle whose closing edge enters DONE, so the write commit or
  // read capture lands exactly on that edge.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    access     = 1'b0;
    stall      = 1'b0;
    rvalid_nxt = 1'b0;
    wack_nxt   = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (request) begin
          stall = 1'b1;
          if (illegal) begin
            // Rejected: skip the wait, touch nothing, report err in DONE.
            state_nxt = ST_DONE;
            err_nxt   = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_nxt  = ST_DONE;
            access     = 1'b1;
            rvalid_nxt = memread;
            wack_nxt   = memwrite;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          // Inputs are held stable by the requester, so the operation type
          // seen here is the one accepted in IDLE.
          state_nxt  = ST_DONE;
          access     = 1'b1;
          rvalid_nxt = memread;
          wack_nxt   = memwrite;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rvalid <= 1'b0;
      wack   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rvalid <= rvalid_nxt;
      wack   <= wack_nxt;
      err    <= err_nxt;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_dmem_array (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (access),
    .we    (memwrite),
    .addr  (addr[IDX_W-1:0]),
    .wdata (wdata),
    .rdata (rdata)
  );

endmodule
